// File: rtl/reg_sequencer.sv
// Fetch/decode/execute/writeback controller that drives a 16x16 register file
// and an external ALU. It issues one instruction per pass, taking at least four cycles.
module reg_sequencer #(
  parameter int unsigned      WIDTH    = 16,
  parameter int unsigned      REGBITS  = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               run,
  output logic [WIDTH-1:0]   pc,
  output logic               instr_req,
  input  logic               instr_valid,
  input  logic [WIDTH-1:0]   instr_data,
  output logic [REGBITS-1:0] sourceAddr,
  output logic [REGBITS-1:0] destAddr,
  output logic               regWrite,
  output logic [WIDTH-1:0]   wrData,
  output logic [3:0]         alu_op,
  output logic               use_imm,
  output logic [WIDTH-1:0]   imm_ext,
  input  logic [WIDTH-1:0]   alu_result,
  output logic               illegal
);

  localparam int unsigned IMMBITS = 8;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_EXEC, S_WB} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]   pc_d, imm_d, wd_d;
  logic [REGBITS-1:0] src_d, dst_d;
  logic [3:0]         op_d;
  logic               ui_d, ill_d, we_d;
  logic               writes_q, writes_d, mov_q, mov_d;

  logic [3:0]         dec_op;
  logic               dec_ui, dec_wr, dec_mov, dec_ill;
  logic [WIDTH-1:0]   dec_imm, sext, zext;

  assign instr_req = reset_n && run && (state_q == S_FETCH);

  // Instruction decode straight off the fetch bus, captured as the fetch completes
  always_comb begin
    dec_op  = 4'h0;
    dec_ui  = 1'b0;
    dec_imm = '0;
    dec_wr  = 1'b0;
    dec_mov = 1'b0;
    dec_ill = 1'b0;
    sext    = WIDTH'($signed(instr_data[IMMBITS-1:0]));
    zext    = WIDTH'(instr_data[IMMBITS-1:0]);
    unique case (instr_data[15:12])
      4'h0: begin dec_op = instr_data[7:4]; dec_wr = (instr_data[7:4] != 4'hB); end
      4'h1: begin dec_op = 4'h5; dec_ui = 1'b1; dec_imm = sext; dec_wr = 1'b1; end
      4'h2: begin dec_op = 4'h9; dec_ui = 1'b1; dec_imm = sext; dec_wr = 1'b1; end
      4'h3: begin dec_op = 4'h1; dec_ui = 1'b1; dec_imm = zext; dec_wr = 1'b1; end
      4'h4: begin dec_op = 4'h2; dec_ui = 1'b1; dec_imm = zext; dec_wr = 1'b1; end
      4'h5: begin dec_op = 4'h3; dec_ui = 1'b1; dec_imm = zext; dec_wr = 1'b1; end
      4'hB: begin dec_op = 4'hB; dec_ui = 1'b1; dec_imm = sext; end
      4'h6: begin dec_ui = 1'b1; dec_imm = zext; dec_wr = 1'b1; dec_mov = 1'b1; end
      4'h7: begin
        dec_ui  = 1'b1;
        dec_imm = WIDTH'({instr_data[IMMBITS-1:0], 8'h00});
        dec_wr  = 1'b1;
        dec_mov = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    pc_d     = pc;
    src_d    = sourceAddr;
    dst_d    = destAddr;
    op_d     = alu_op;
    ui_d     = use_imm;
    imm_d    = imm_ext;
    writes_d = writes_q;
    mov_d    = mov_q;
    wd_d     = wrData;
    ill_d    = 1'b0;
    we_d     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        if (instr_req && instr_valid) begin
          pc_d     = pc + WIDTH'(1);
          src_d    = REGBITS'(instr_data[3:0]);
          dst_d    = REGBITS'(instr_data[11:8]);
          op_d     = dec_op;
          ui_d     = dec_ui;
          imm_d    = dec_imm;
          writes_d = dec_wr;
          mov_d    = dec_mov;
          ill_d    = dec_ill;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        // wrData doubles as the result register: ALU result or the move immediate
        wd_d    = mov_q ? imm_ext : alu_result;
        we_d    = writes_q;
        state_d = S_WB;
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_FETCH;
      pc         <= RESET_PC;
      sourceAddr <= '0;
      destAddr   <= '0;
      alu_op     <= 4'h0;
      use_imm    <= 1'b0;
      imm_ext    <= '0;
      writes_q   <= 1'b0;
      mov_q      <= 1'b0;
      wrData     <= '0;
      illegal    <= 1'b0;
      regWrite   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      sourceAddr <= src_d;
      destAddr   <= dst_d;
      alu_op     <= op_d;
      use_imm    <= ui_d;
      imm_ext    <= imm_d;
      writes_q   <= writes_d;
      mov_q      <= mov_d;
      wrData     <= wd_d;
      illegal    <= ill_d;
      regWrite   <= we_d;
    end
  end

endmodule

// File: tb/tb_reg_sequencer.sv
// Bench for reg_sequencer: directed instructions with literal expectations,
// then random traffic checked every cycle against an instruction-level model.
module tb_reg_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run, instr_valid;
  logic [15:0] instr_data, alu_result;

  logic [15:0] pc, wrData, imm_ext;
  logic [3:0]  sourceAddr, destAddr, alu_op;
  logic        instr_req, regWrite, use_imm, illegal;

  logic [15:0] w_pc, w_wrData, w_imm_ext;
  logic [3:0]  w_sourceAddr, w_destAddr, w_alu_op;
  logic        w_instr_req, w_regWrite, w_use_imm, w_illegal;

  int total = 0;
  int bad   = 0;

  reg_sequencer u_dut (
    .clk(clk), .reset_n(reset_n), .run(run), .pc(pc), .instr_req(instr_req),
    .instr_valid(instr_valid), .instr_data(instr_data), .sourceAddr(sourceAddr),
    .destAddr(destAddr), .regWrite(regWrite), .wrData(wrData), .alu_op(alu_op),
    .use_imm(use_imm), .imm_ext(imm_ext), .alu_result(alu_result), .illegal(illegal)
  );

  // Second copy starting at the top of the address space to exercise PC wrap
  reg_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .reset_n(reset_n), .run(run), .pc(w_pc), .instr_req(w_instr_req),
    .instr_valid(instr_valid), .instr_data(instr_data), .sourceAddr(w_sourceAddr),
    .destAddr(w_destAddr), .regWrite(w_regWrite), .wrData(w_wrData), .alu_op(w_alu_op),
    .use_imm(w_use_imm), .imm_ext(w_imm_ext), .alu_result(alu_result), .illegal(w_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  op;
    logic        op_care;
    logic        ui;
    logic        ui_care;
    logic [15:0] imm;
    logic        imm_care;
    logic        wr;
    logic        mov;
    logic        ill;
  } dec_t;

  function automatic dec_t decode_ref(input logic [15:0] ins);
    dec_t d;
    int   lo;
    logic [15:0] s16, z16;
    d   = '0;
    lo  = int'(ins[7:0]);
    z16 = 16'(lo);
    s16 = (lo >= 128) ? 16'(lo - 256) : 16'(lo);
    d.ui_care = 1'b1;
    case (int'(ins[15:12]))
      0:  begin d.op = ins[7:4]; d.op_care = 1; d.ui = 0; d.wr = (ins[7:4] != 4'd11); end
      1:  begin d.op = 4'd5;  d.op_care = 1; d.ui = 1; d.imm = s16; d.imm_care = 1; d.wr = 1; end
      2:  begin d.op = 4'd9;  d.op_care = 1; d.ui = 1; d.imm = s16; d.imm_care = 1; d.wr = 1; end
      3:  begin d.op = 4'd1;  d.op_care = 1; d.ui = 1; d.imm = z16; d.imm_care = 1; d.wr = 1; end
      4:  begin d.op = 4'd2;  d.op_care = 1; d.ui = 1; d.imm = z16; d.imm_care = 1; d.wr = 1; end
      5:  begin d.op = 4'd3;  d.op_care = 1; d.ui = 1; d.imm = z16; d.imm_care = 1; d.wr = 1; end
      11: begin d.op = 4'd11; d.op_care = 1; d.ui = 1; d.imm = s16; d.imm_care = 1; d.wr = 0; end
      6:  begin d.ui = 1; d.imm = z16; d.imm_care = 1; d.wr = 1; d.mov = 1; end
      7:  begin d.ui = 1; d.imm = 16'(lo * 256); d.imm_care = 1; d.wr = 1; d.mov = 1; end
      default: begin d.ill = 1; d.ui_care = 0; end
    endcase
    return d;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: phase 0..3 = fetch, decode, exec, writeback
  int          phase;
  logic [15:0] m_pc, m_res;
  logic [3:0]  m_src, m_dst;
  dec_t        m_d;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase = 0;
      m_pc  = 16'h0000;
      m_res = 16'h0000;
      m_src = 4'h0;
      m_dst = 4'h0;
      m_d   = decode_ref(16'h0000);
    end else begin
      case (phase)
        0: if (run && instr_valid) begin
             m_d   = decode_ref(instr_data);
             m_src = instr_data[3:0];
             m_dst = instr_data[11:8];
             m_pc  = 16'(m_pc + 16'd1);
             phase = 1;
           end
        1: phase = 2;
        2: begin m_res = alu_result; phase = 3; end
        default: phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("pc", pc, m_pc);
    check("wrap_pc", w_pc, 16'(m_pc + 16'hFFFF));
    check("instr_req", 16'(instr_req), 16'(reset_n && phase == 0 && run));
    check("illegal", 16'(illegal), 16'(reset_n && phase == 1 && m_d.ill));
    check("regWrite", 16'(regWrite), 16'(reset_n && phase == 3 && m_d.wr));
    if (!reset_n) begin
      check("rst_src", 16'(sourceAddr), 16'h0);
      check("rst_dst", 16'(destAddr), 16'h0);
      check("rst_op", 16'(alu_op), 16'h0);
      check("rst_use_imm", 16'(use_imm), 16'h0);
      check("rst_imm", imm_ext, 16'h0);
      check("rst_wrData", wrData, 16'h0);
    end else if (phase != 0) begin
      check("sourceAddr", 16'(sourceAddr), 16'(m_src));
      check("destAddr", 16'(destAddr), 16'(m_dst));
      if (m_d.op_care)  check("alu_op", 16'(alu_op), 16'(m_d.op));
      if (m_d.ui_care)  check("use_imm", 16'(use_imm), 16'(m_d.ui));
      if (m_d.imm_care) check("imm_ext", imm_ext, m_d.imm);
      if (phase == 3 && !m_d.ill) check("wrData", wrData, m_d.mov ? m_d.imm : m_res);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Presents one instruction, starting in FETCH; returns in DECODE at posedge+2
  task automatic issue(input logic [15:0] ins, input logic [15:0] ar, input int stall);
    run = 1'b1;
    instr_valid = 1'b0;
    repeat (stall) tick();
    instr_valid = 1'b1;
    instr_data  = ins;
    alu_result  = ar;
    tick();
    instr_valid = 1'b0;
    instr_data  = 16'($urandom);
  endtask

  task automatic to_wb();
    tick();
    tick();
    @(negedge clk);
  endtask

  initial begin
    run = 1'b0; instr_valid = 1'b0; instr_data = '0; alu_result = '0;
    repeat (4) begin
      tick();
      run = 1'($urandom); instr_valid = 1'($urandom);
      instr_data = 16'($urandom); alu_result = 16'($urandom);
    end
    tick();
    run = 1'b1; instr_valid = 1'b0; reset_n = 1'b1;
    @(negedge clk);
    check("lit_req_after_reset", 16'(instr_req), 16'h1);
    check("lit_pc_after_reset", pc, 16'h0000);

    issue(16'h13FE, 16'h0010, 0);
    @(negedge clk);
    check("lit_addi_op", 16'(alu_op), 16'h5);
    check("lit_addi_use_imm", 16'(use_imm), 16'h1);
    check("lit_addi_imm", imm_ext, 16'hFFFE);
    check("lit_addi_pc", pc, 16'h0001);
    check("lit_wrap_pc", w_pc, 16'h0000);
    to_wb();
    check("lit_addi_dst", 16'(destAddr), 16'h3);
    check("lit_addi_we", 16'(regWrite), 16'h1);
    check("lit_addi_wd", wrData, 16'h0010);
    tick();

    issue(16'h75AB, 16'h1234, 0);
    to_wb();
    check("lit_lui_we", 16'(regWrite), 16'h1);
    check("lit_lui_wd", wrData, 16'hAB00);
    tick();
    issue(16'h65CD, 16'h5555, 0);
    to_wb();
    check("lit_movi_wd", wrData, 16'h00CD);
    check("lit_movi_dst", 16'(destAddr), 16'h5);
    tick();

    issue(16'h01B2, 16'h7777, 0);
    @(negedge clk);
    check("lit_cmp_op", 16'(alu_op), 16'hB);
    to_wb();
    check("lit_cmp_we", 16'(regWrite), 16'h0);
    tick();
    issue(16'hF123, 16'h1111, 0);
    @(negedge clk);
    check("lit_ill_pulse", 16'(illegal), 16'h1);
    tick();
    @(negedge clk);
    check("lit_ill_drop", 16'(illegal), 16'h0);
    tick();
    @(negedge clk);
    check("lit_ill_we", 16'(regWrite), 16'h0);
    tick();

    issue(16'h1001, 16'h2222, 5);
    @(negedge clk);
    check("lit_stall_pc", pc, 16'h0006);
    to_wb();
    tick();

    issue(16'h13FE, 16'h0042, 0);
    to_wb();
    check("lit_midwb_we_before", 16'(regWrite), 16'h1);
    #1 reset_n = 1'b0;
    #1;
    check("lit_midwb_we_after", 16'(regWrite), 16'h0);
    check("lit_midwb_pc", pc, 16'h0000);
    check("lit_midwb_wrap_pc", w_pc, 16'hFFFF);
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      tick();
      run         = ($urandom % 8) != 0;
      instr_valid = ($urandom % 3) != 0;
      instr_data  = 16'($urandom);
      alu_result  = 16'($urandom);
      reset_n     = ($urandom % 200) != 0;
    end
    tick();
    reset_n = 1'b1;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_sequencer.md
Name: reg_sequencer

Overview:
- Multi-cycle fetch/decode/execute/writeback controller sitting directly upstream of the 16x16 register file.
- Fetches one 16-bit instruction per pass and decodes it.
- Drives the register file's read and write addresses, write enable and write data, plus ALU control.
- The ALU is external: it consumes register-file read data and this block's immediate, and returns its result to this block for writeback.

Parameters:
- WIDTH, 16, datapath and instruction width.
- REGBITS, 4, register address width (16 registers; r0 reads as zero in the register file).
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  when 0, no new fetch starts; an instruction already in flight completes.
- pc  out  WIDTH  instruction address; valid while instr_req=1.
- instr_req  out  1  fetch request.
- instr_valid  in  1  memory returns instr_data this cycle.
- instr_data  in  WIDTH  fetched instruction.
- sourceAddr  out  REGBITS  register-file read address, port 2 (IR[3:0]).
- destAddr  out  REGBITS  register-file read port 1 and write address (IR[11:8]).
- regWrite  out  1  register-file write enable.
- wrData  out  WIDTH  register-file write data.
- alu_op  out  4  ALU operation code.
- use_imm  out  1  ALU B operand = imm_ext instead of readData2.
- imm_ext  out  WIDTH  extended immediate.
- alu_result  in  WIDTH  ALU output, sampled at end of EXEC.
- illegal  out  1  one-cycle pulse in DECODE for an undefined opcode.

Behaviour:
- Reset (async, reset_n=0) forces:
  - state=FETCH, pc=RESET_PC, IR=0, result reg=0.
  - regWrite=0, instr_req=0, illegal=0, wrData=0, alu_op=0, use_imm=0, imm_ext=0.
  - sourceAddr=0, destAddr=0.
  - Reset asserted mid-instruction aborts it: no write occurs, even if reset lands in WB.
- States: FETCH -> DECODE -> EXEC -> WB -> FETCH.
- FETCH:
  - instr_req = run (combinational from state and run).
  - On instr_valid=1 with instr_req=1: IR<=instr_data, pc<=pc+1 (wraps 16'hFFFF->0), go to DECODE.
  - Otherwise stay in FETCH.
  - instr_valid is ignored when instr_req=0.
- DECODE (1 cycle):
  - sourceAddr/destAddr come from IR; they are held from DECODE through WB.
  - alu_op, use_imm and imm_ext are decoded and held through WB.
- EXEC (1 cycle): result reg <= alu_result at the end of the cycle.
- WB (1 cycle):
  - regWrite=1 only if the opcode writes (see decode below).
  - wrData = result reg for ALU ops, imm_ext for MOVI/LUI.
  - regWrite is 0 in every other state.
- Latency: minimum 4 cycles per instruction (FETCH with instr_valid already high, then DECODE, EXEC, WB). Each cycle instr_valid is late extends FETCH by 1.
- Decode, by IR[15:12]:
  - 0000 R-type: alu_op=IR[7:4], use_imm=0. Writes unless IR[7:4]=1011 (CMP).
  - 0001 ADDI: alu_op=0101, sign-extended IR[7:0]. Writes.
  - 0010 SUBI: alu_op=1001, sign-extended. Writes.
  - 0011 ANDI: alu_op=0001, zero-extended. Writes.
  - 0100 ORI: alu_op=0010, zero-extended. Writes.
  - 0101 XORI: alu_op=0011, zero-extended. Writes.
  - 1011 CMPI: alu_op=1011, sign-extended. No write.
  - 0110 MOVI: imm_ext = zero-extended IR[7:0]. Writes.
  - 0111 LUI: imm_ext = {IR[7:0], 8'h00}. Writes.
  - use_imm=1 for every immediate form.
  - Any other opcode: illegal=1 in DECODE, then treated as NOP (EXEC and WB still occur, no write).
- Writes to r0 are issued normally; the register file's r0 read-as-zero handling is unchanged.
- run dropping during DECODE/EXEC/WB does not stop the current instruction. It only blocks the next FETCH request.

Test Plan:
- Reset: hold reset_n=0 over random inputs -> pc=0000, instr_req=0, regWrite=0. Release with run=1 -> instr_req=1 on the next cycle.
- ADDI r3,#-2 (0x13FE), instr_valid immediate, alu_result=0x0010 -> use_imm=1, imm_ext=0xFFFE, alu_op=0101. In WB: destAddr=3, regWrite=1, wrData=0x0010. pc=0001 after fetch.
- LUI r5,#0xAB (0x75AB) then MOVI r5,#0xCD (0x65CD) -> WB writes 0xAB00, then 0x00CD. The ALU result is ignored in both.
- CMP r1,r2 (0x01B2) and opcode 1111 -> no regWrite for either. The 1111 instruction gives a one-cycle illegal pulse in DECODE.
- Stall: instr_valid held low 5 cycles -> FETCH holds with pc and instr_req stable. Then a normal 4-cycle completion. A pc=FFFF fetch wraps pc to 0000.
- Reset mid-WB of ADDI: reset_n low during WB -> regWrite drops immediately, no write occurs. pc returns to RESET_PC.
